// File: rtl/layer_compositor_if.sv
// Pixel-side bus of the layer compositor: layer/background/overlay inputs and composited outputs.
interface layer_compositor_if #(
    parameter int unsigned N_LAYERS = 4,
    parameter int unsigned FADE_W   = 4
);
    localparam int unsigned WIN_W = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1;

    logic                     fsync;
    logic                     active;
    logic [24*N_LAYERS-1:0]   layer_pixel;
    logic [N_LAYERS-1:0]      layer_valid;
    logic [N_LAYERS-1:0]      layer_en_req;
    logic [23:0]              bg_pixel;
    logic [23:0]              overlay_pixel;
    logic                     overlay_req;
    logic [23:0]              pixel_out;
    logic                     active_out;
    logic [WIN_W-1:0]         win_layer;
    logic                     win_valid;
    logic [FADE_W:0]          alpha;
    logic                     fade_busy;

    modport master (
        output fsync, active, layer_pixel, layer_valid, layer_en_req,
               bg_pixel, overlay_pixel, overlay_req,
        input  pixel_out, active_out, win_layer, win_valid, alpha, fade_busy
    );

    modport slave (
        input  fsync, active, layer_pixel, layer_valid, layer_en_req,
               bg_pixel, overlay_pixel, overlay_req,
        output pixel_out, active_out, win_layer, win_valid, alpha, fade_busy
    );
endinterface

// File: rtl/layer_compositor.sv
// Fixed-priority sprite layer merge over a background, followed by a frame-stepped
// alpha fade towards a full-screen overlay. Two-cycle pipeline, pixel_clk domain.
module layer_compositor #(
    parameter int unsigned N_LAYERS  = 4,
    parameter int unsigned FADE_W    = 4,
    parameter int unsigned FADE_STEP = 1
) (
    input  logic               pixel_clk,
    input  logic               rst,
    layer_compositor_if.slave  bus
);
    localparam int unsigned WIN_W = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1;
    localparam int unsigned AW    = FADE_W + 1;
    localparam int unsigned MW    = 8 + FADE_W + 1;
    localparam int unsigned M     = 1 << FADE_W;

    typedef enum logic [1:0] {IDLE, FADE_IN, HOLD, FADE_OUT} fade_state_e;

    fade_state_e          state_q, state_d;
    logic [AW-1:0]        alpha_q, alpha_d;
    logic                 busy_q, busy_d;
    logic [N_LAYERS-1:0]  shadow_q, shadow_d;

    logic [23:0]          s1_base_q, s1_base_d;
    logic [23:0]          s1_ov_q, s1_ov_d;
    logic [WIN_W-1:0]     s1_win_q, s1_win_d;
    logic                 s1_wv_q, s1_wv_d;
    logic                 s1_act_q, s1_act_d;

    logic [23:0]          pix_q, pix_d;
    logic                 act_out_q, act_out_d;
    logic [WIN_W-1:0]     win_q, win_d;
    logic                 wv_q, wv_d;

    logic [AW-1:0]        alpha_up, alpha_dn;

    // Saturating alpha steps, computed wide so a STEP that does not divide M cannot wrap
    assign alpha_up = ((32'(alpha_q) + FADE_STEP) >= M) ? AW'(M)
                                                        : AW'(32'(alpha_q) + FADE_STEP);
    assign alpha_dn = (32'(alpha_q) <= FADE_STEP) ? '0 : AW'(32'(alpha_q) - FADE_STEP);

    function automatic logic [7:0] blend_byte(input logic [7:0] ov, input logic [7:0] base,
                                              input logic [AW-1:0] a);
        logic [MW-1:0] sum;
        sum = MW'(ov) * MW'(a) + MW'(base) * MW'(AW'(M) - a);
        return 8'(sum >> FADE_W);
    endfunction

    always_comb begin
        shadow_d = shadow_q;
        state_d  = state_q;
        alpha_d  = alpha_q;

        // Enables and fade only advance at frame start
        if (bus.fsync) begin
            shadow_d = bus.layer_en_req;
            case (state_q)
                IDLE: begin
                    if (bus.overlay_req) begin
                        state_d = FADE_IN;
                        alpha_d = alpha_up;
                    end
                end
                FADE_IN: begin
                    if (!bus.overlay_req) begin
                        state_d = FADE_OUT;
                        alpha_d = alpha_dn;
                    end else begin
                        alpha_d = alpha_up;
                        if (alpha_up == AW'(M)) state_d = HOLD;
                    end
                end
                HOLD: begin
                    if (!bus.overlay_req) begin
                        state_d = FADE_OUT;
                        alpha_d = alpha_dn;
                    end
                end
                FADE_OUT: begin
                    if (bus.overlay_req) begin
                        state_d = FADE_IN;
                        alpha_d = alpha_up;
                    end else begin
                        alpha_d = alpha_dn;
                        if (alpha_dn == '0) state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        busy_d = (state_d == FADE_IN) || (state_d == FADE_OUT);

        // Stage 1: lowest eligible index wins, scanned high-to-low so the last hit is the winner
        s1_base_d = bus.bg_pixel;
        s1_win_d  = '0;
        s1_wv_d   = 1'b0;
        for (int i = int'(N_LAYERS) - 1; i >= 0; i--) begin
            if (bus.layer_valid[i] && shadow_q[i]) begin
                s1_base_d = bus.layer_pixel[24*i +: 24];
                s1_win_d  = WIN_W'(i);
                s1_wv_d   = 1'b1;
            end
        end
        s1_ov_d  = bus.overlay_pixel;
        s1_act_d = bus.active;

        // Stage 2: per-byte overlay blend using the frame-constant registered alpha
        pix_d = '0;
        if (s1_act_q) begin
            for (int c = 0; c < 3; c++)
                pix_d[8*c +: 8] = blend_byte(s1_ov_q[8*c +: 8], s1_base_q[8*c +: 8], alpha_q);
        end
        act_out_d = s1_act_q;
        win_d     = s1_win_q;
        wv_d      = s1_wv_q;
    end

    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            alpha_q   <= '0;
            busy_q    <= 1'b0;
            shadow_q  <= '1;
            s1_base_q <= '0;
            s1_ov_q   <= '0;
            s1_win_q  <= '0;
            s1_wv_q   <= 1'b0;
            s1_act_q  <= 1'b0;
            pix_q     <= '0;
            act_out_q <= 1'b0;
            win_q     <= '0;
            wv_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            alpha_q   <= alpha_d;
            busy_q    <= busy_d;
            shadow_q  <= shadow_d;
            s1_base_q <= s1_base_d;
            s1_ov_q   <= s1_ov_d;
            s1_win_q  <= s1_win_d;
            s1_wv_q   <= s1_wv_d;
            s1_act_q  <= s1_act_d;
            pix_q     <= pix_d;
            act_out_q <= act_out_d;
            win_q     <= win_d;
            wv_q      <= wv_d;
        end
    end

    assign bus.pixel_out  = pix_q;
    assign bus.active_out = act_out_q;
    assign bus.win_layer  = win_q;
    assign bus.win_valid  = wv_q;
    assign bus.alpha      = alpha_q;
    assign bus.fade_busy  = busy_q;
endmodule

// File: tb/tb_layer_compositor.sv
// Randomised and directed bench for layer_compositor: two instances (STEP=1 and STEP=5)
// share one stimulus stream and are compared against a frame-level reference model.
module tb_layer_compositor;
    localparam int N  = 4;
    localparam int FW = 4;
    localparam int M  = 16;

    logic pixel_clk = 1'b0;
    logic rst       = 1'b1;
    always #5 pixel_clk = ~pixel_clk;

    layer_compositor_if #(.N_LAYERS(N), .FADE_W(FW)) bus1 ();
    layer_compositor_if #(.N_LAYERS(N), .FADE_W(FW)) bus5 ();

    layer_compositor #(.N_LAYERS(N), .FADE_W(FW), .FADE_STEP(1)) dut1 (
        .pixel_clk(pixel_clk), .rst(rst), .bus(bus1.slave));
    layer_compositor #(.N_LAYERS(N), .FADE_W(FW), .FADE_STEP(5)) dut5 (
        .pixel_clk(pixel_clk), .rst(rst), .bus(bus5.slave));

    typedef struct {
        logic [23:0] pix;
        bit          act;
        bit          wv;
        int          win;
    } exp_t;

    exp_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    // current stimulus
    bit          fs, act, req;
    logic [95:0] lp;
    logic [3:0]  lv, en;
    logic [23:0] bg, ov;

    // reference model state
    logic [3:0]  shadow_m;
    int          a1, a5;
    bit          busy1, busy5, up1, up5;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int clamp(input int v);
        return (v < 0) ? 0 : ((v > M) ? M : v);
    endfunction

    // One frame-boundary update of the overlay fade for a given step size
    task automatic fade_model(input int step, input bit r, inout int a, inout bit busy, inout bit up);
        if (!busy) begin
            if (a == 0 && r)       begin a = clamp(a + step); busy = 1; up = 1; end
            else if (a == M && !r) begin a = clamp(a - step); busy = 1; up = 0; end
        end else if (r) begin
            a = clamp(a + step);
            if (up && a == M) busy = 0;
            up = 1;
        end else begin
            a = clamp(a - step);
            if (!up && a == 0) busy = 0;
            up = 0;
        end
    endtask

    function automatic logic [23:0] mix(input logic [23:0] o, input logic [23:0] b, input int a);
        logic [23:0] r;
        for (int c = 0; c < 3; c++)
            r[8*c +: 8] = 8'((int'(o[8*c +: 8]) * a + int'(b[8*c +: 8]) * (M - a)) / M);
        return r;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        shadow_m = 4'hF;
        a1 = 0; a5 = 0; busy1 = 0; busy5 = 0; up1 = 0; up5 = 0;
    endtask

    // One pixel clock: check what is due, drive the current stimulus, predict its result
    task automatic step();
        exp_t e;
        @(negedge pixel_clk);
        if (exp_q.size() == 2) begin
            e = exp_q.pop_front();
            chk("pixel_out", 32'(bus1.pixel_out), 32'(e.pix));
            chk("active_out", 32'(bus1.active_out), 32'(e.act));
            chk("win_valid", 32'(bus1.win_valid), 32'(e.wv));
            if (e.wv) chk("win_layer", 32'(bus1.win_layer), 32'(e.win));
        end
        chk("alpha_s1", 32'(bus1.alpha), 32'(a1));
        chk("busy_s1", 32'(bus1.fade_busy), 32'(busy1));
        chk("alpha_s5", 32'(bus5.alpha), 32'(a5));
        chk("busy_s5", 32'(bus5.fade_busy), 32'(busy5));

        bus1.fsync = fs; bus1.active = act; bus1.layer_pixel = lp; bus1.layer_valid = lv;
        bus1.layer_en_req = en; bus1.bg_pixel = bg; bus1.overlay_pixel = ov; bus1.overlay_req = req;
        bus5.fsync = fs; bus5.active = act; bus5.layer_pixel = lp; bus5.layer_valid = lv;
        bus5.layer_en_req = en; bus5.bg_pixel = bg; bus5.overlay_pixel = ov; bus5.overlay_req = req;

        if (fs) begin
            fade_model(1, req, a1, busy1, up1);
            fade_model(5, req, a5, busy5, up5);
        end
        e.pix = bg; e.wv = 0; e.win = 0; e.act = act;
        for (int i = 0; i < N; i++) begin
            if (lv[i] && shadow_m[i]) begin
                e.pix = lp[24*i +: 24]; e.wv = 1; e.win = i;
                break;
            end
        end
        e.pix = act ? mix(ov, e.pix, a1) : 24'h0;
        exp_q.push_back(e);
        if (fs) shadow_m = en;
    endtask

    task automatic idle();
        fs = 0; act = 0; lv = '0;
        step();
    endtask

    task automatic frame(input bit r);
        req = r; fs = 1; act = 0; lv = '0;
        step();
        idle();
        idle();
    endtask

    task automatic do_reset();
        @(negedge pixel_clk);
        rst = 1'b1;
        model_reset();
        @(negedge pixel_clk);
        rst = 1'b0;
    endtask

    initial begin
        fs = 0; act = 0; req = 0; lp = '0; lv = '0; en = 4'hF; bg = '0; ov = '0;
        bus1.fsync = 0; bus1.active = 0; bus1.layer_pixel = '0; bus1.layer_valid = '0;
        bus1.layer_en_req = 4'hF; bus1.bg_pixel = '0; bus1.overlay_pixel = '0; bus1.overlay_req = 0;
        bus5.fsync = 0; bus5.active = 0; bus5.layer_pixel = '0; bus5.layer_valid = '0;
        bus5.layer_en_req = 4'hF; bus5.bg_pixel = '0; bus5.overlay_pixel = '0; bus5.overlay_req = 0;
        model_reset();
        repeat (3) @(negedge pixel_clk);
        chk("rst_pixel", 32'(bus1.pixel_out), 32'h0);
        chk("rst_alpha", 32'(bus1.alpha), 32'h0);
        chk("rst_win_valid", 32'(bus1.win_valid), 32'h0);
        rst = 1'b0;

        // Priority with default all-ones shadow
        lp = '0; lp[47:24] = 24'hFF0000; lp[71:48] = 24'h00FF00;
        fs = 0; act = 1; lv = 4'b0110; step();
        idle(); idle();
        chk("prio_pix", 32'(bus1.pixel_out), 32'hFF0000);
        chk("prio_win", 32'(bus1.win_layer), 32'd1);

        // Mid-frame enable change is ignored until fsync
        en = 4'b1101; act = 1; lv = 4'b0110; step();
        idle(); idle();
        chk("en_hold_win", 32'(bus1.win_layer), 32'd1);
        fs = 1; act = 1; lv = 4'b0110; step();
        fs = 0; act = 1; lv = 4'b0110; step();
        idle();
        chk("en_fsync_win", 32'(bus1.win_layer), 32'd1);
        idle();
        chk("en_new_win", 32'(bus1.win_layer), 32'd2);
        chk("en_new_pix", 32'(bus1.pixel_out), 32'h00FF00);

        // Background and blanking
        bg = 24'h102030; act = 1; lv = '0; step();
        act = 0; step();
        idle();
        chk("bg_pix", 32'(bus1.pixel_out), 32'h102030);
        chk("bg_wv", 32'(bus1.win_valid), 32'h0);
        idle();
        chk("blank_pix", 32'(bus1.pixel_out), 32'h0);
        chk("blank_act", 32'(bus1.active_out), 32'h0);

        // STEP=5 rising to 15 then reversal down to IDLE
        do_reset();
        en = 4'hF;
        for (int k = 1; k <= 3; k++) frame(1);
        chk("s5_rise15", 32'(bus5.alpha), 32'd15);
        for (int k = 1; k <= 3; k++) begin
            frame(0);
            chk("s5_fall", 32'(bus5.alpha), 32'(15 - 5 * k));
        end
        chk("s5_idle_busy", 32'(bus5.fade_busy), 32'd0);

        // Full fade-in for both instances, with a 50% blend check at alpha=8
        for (int k = 1; k <= 16; k++) begin
            frame(1);
            chk("s1_fade_in", 32'(bus1.alpha), 32'(k));
            chk("s5_fade_in", 32'(bus5.alpha), 32'((5 * k > 16) ? 16 : 5 * k));
            if (k == 8) begin
                bg = 24'h0; ov = 24'hFFFFFF; act = 1; lv = '0; step();
                idle(); idle();
                chk("half_blend", 32'(bus1.pixel_out), 32'h7F7F7F);
            end
        end
        chk("hold_busy", 32'(bus1.fade_busy), 32'd0);

        // Randomised frames with random layer/enable/overlay activity
        for (int cyc = 0; cyc < 3000; cyc++) begin
            fs  = (cyc % 23) == 0;
            act = $urandom_range(0, 7) != 0;
            lp  = {$urandom, $urandom, $urandom};
            lv  = 4'($urandom);
            bg  = 24'($urandom);
            ov  = 24'($urandom);
            if ($urandom_range(0, 9) == 0) en = 4'($urandom);
            if (fs && $urandom_range(0, 5) == 0) req = ~req;
            step();
        end
        idle(); idle();

        // Asynchronous reset in the middle of a fade
        do_reset();
        en = 4'hF;
        for (int k = 1; k <= 9; k++) frame(1);
        chk("pre_rst_alpha", 32'(bus1.alpha), 32'd9);
        bg = 24'hABCDEF; act = 1; lv = '0; ov = 24'h0; step();
        idle();
        @(negedge pixel_clk);
        #2 rst = 1'b1;
        #1;
        chk("async_alpha", 32'(bus1.alpha), 32'd0);
        chk("async_pix", 32'(bus1.pixel_out), 32'd0);
        chk("async_busy", 32'(bus1.fade_busy), 32'd0);
        model_reset();
        @(negedge pixel_clk);
        rst = 1'b0;
        // Shadow must be back to all ones: layer 3 alone must win
        lp = '0; lp[95:72] = 24'h0000AA; act = 1; lv = 4'b1000; fs = 0; step();
        idle(); idle();
        chk("rst_shadow_win", 32'(bus1.win_layer), 32'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
